// File: rtl/linha_envase_pkg.sv
// Shared types and defaults for the bottle-filling station controller.
// State encodings are fixed because Estado is exported for debug.
package linha_envase_pkg;
  localparam int ESTADO_W         = 3;
  localparam int FILL_TIMEOUT_DEF = 200;
  localparam int CAP_CYCLES_DEF   = 8;
  localparam int CRATE_SIZE_DEF   = 6;
  localparam int CNT_W_DEF        = 4;

  typedef enum logic [ESTADO_W-1:0] {
    IDLE   = 3'd0,
    AVANCA = 3'd1,
    ENCHE  = 3'd2,
    TAMPA  = 3'd3,
    SAI    = 3'd4,
    ERRO   = 3'd5
  } estado_t;

  typedef struct packed {
    logic motor;
    logic valvula;
    logic tampar;
    logic alarme;
  } atua_t;

  // Actuator image of a state; registered from the next state so outputs track Estado
  function automatic atua_t decodifica(estado_t e);
    atua_t a;
    a         = '0;
    a.motor   = (e == AVANCA) || (e == SAI);
    a.valvula = (e == ENCHE);
    a.tampar  = (e == TAMPA);
    a.alarme  = (e == ERRO);
    return a;
  endfunction
endpackage

// File: rtl/temporizador_envase.sv
// Per-state cycle timer: cleared on state entry, saturates instead of wrapping.
module temporizador_envase #(
  parameter int W = 8
) (
  input  logic         CK,
  input  logic         nRST,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic         fim
);
  logic [W-1:0] cnt;

  always_ff @(posedge CK or negedge nRST) begin
    if (!nRST)                        cnt <= '0;
    else if (clr)                     cnt <= '0;
    else if (en && cnt != {W{1'b1}})  cnt <= cnt + 1'b1;
  end

  assign fim = en && (cnt == lim);
endmodule

// File: rtl/controle_linha_envase.sv
// Bottle-filling station sequencer: advance, fill, cap, eject, with crate count and alarm.
// Optional lifetime bottle counter output Total enabled by defining TOTAL_CNT_EN.
module controle_linha_envase
  import linha_envase_pkg::*;
#(
  parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEF,
  parameter int CAP_CYCLES   = CAP_CYCLES_DEF,
  parameter int CRATE_SIZE   = CRATE_SIZE_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                CK,
  input  logic                nRST,
  input  logic                Start,
  input  logic                TemR,
  input  logic                TemG,
  input  logic                Cheia,
  input  logic                AckAlarme,
  output logic                Motor,
  output logic                Valvula,
  output logic                Tampar,
  output logic                Pronto,
  output logic                Alarme,
  output logic [ESTADO_W-1:0] Estado,
  output logic [CNT_W-1:0]    Contagem
`ifdef TOTAL_CNT_EN
  ,
  output logic [15:0]         Total
`endif
);
  localparam int TMR_MAX = (FILL_TIMEOUT > CAP_CYCLES) ? FILL_TIMEOUT : CAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  estado_t          estado, nxt;
  logic             fim, clr, en, capFim;
  logic [TMR_W-1:0] lim;
  logic [CNT_W-1:0] cntInc;

  assign en     = (estado == ENCHE) || (estado == TAMPA) || (estado == SAI);
  assign lim    = (estado == TAMPA) ? TMR_W'(CAP_CYCLES - 1) : TMR_W'(FILL_TIMEOUT - 1);
  assign clr    = (nxt != estado);
  assign capFim = (estado == TAMPA) && fim;
  assign cntInc = Contagem + 1'b1;
  assign Estado = estado;

  temporizador_envase #(.W(TMR_W)) uTmr (
    .CK   (CK),
    .nRST (nRST),
    .clr  (clr),
    .en   (en),
    .lim  (lim),
    .fim  (fim)
  );

  always_comb begin
    nxt = estado;
    case (estado)
      IDLE:   if (Start) nxt = TemR ? AVANCA : ERRO;
      AVANCA: if (!TemR) nxt = ERRO;
              else if (!Start) nxt = IDLE;
              else if (TemG) nxt = ENCHE;
      // Reservoir loss beats a full bottle; a full bottle beats the timeout
      ENCHE:  if (!TemR) nxt = ERRO;
              else if (Cheia) nxt = TAMPA;
              else if (fim) nxt = ERRO;
      TAMPA:  if (fim) nxt = SAI;
      SAI:    if (!TemG) nxt = Start ? AVANCA : IDLE;
              else if (fim) nxt = ERRO;
      ERRO:   if (AckAlarme && TemR) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge nRST) begin
    if (!nRST) begin
      estado                          <= IDLE;
      {Motor, Valvula, Tampar, Alarme} <= '0;
      Pronto                          <= 1'b0;
      Contagem                        <= '0;
    end else begin
      estado                          <= nxt;
      {Motor, Valvula, Tampar, Alarme} <= decodifica(nxt);
      Pronto                          <= 1'b0;
      if (capFim) begin
        if (cntInc == CNT_W'(CRATE_SIZE)) begin
          Contagem <= '0;
          Pronto   <= 1'b1;
        end else begin
          Contagem <= cntInc;
        end
      end
    end
  end

`ifdef TOTAL_CNT_EN
  always_ff @(posedge CK or negedge nRST) begin
    if (!nRST)                          Total <= '0;
    else if (capFim && Total != 16'hFFFF) Total <= Total + 16'd1;
  end
`endif
endmodule

// File: tb/tb_controle_linha_envase.sv
// Scoreboard bench for controle_linha_envase: a cycle model pushes expected outputs, DUT samples pop them.
module tb_controle_linha_envase;
  localparam int FT = 200;
  localparam int CC = 8;
  localparam int CS = 6;

  logic        CK, nRST, Start, TemR, TemG, Cheia, AckAlarme;
  logic        Motor, Valvula, Tampar, Pronto, Alarme;
  logic [2:0]  Estado;
  logic [3:0]  Contagem;
  logic [15:0] totDut;
`ifdef TOTAL_CNT_EN
  logic [15:0] Total;
  assign totDut = Total;
`else
  assign totDut = 16'd0;
`endif

  controle_linha_envase dut (
    .CK(CK), .nRST(nRST), .Start(Start), .TemR(TemR), .TemG(TemG), .Cheia(Cheia),
    .AckAlarme(AckAlarme), .Motor(Motor), .Valvula(Valvula), .Tampar(Tampar),
    .Pronto(Pronto), .Alarme(Alarme), .Estado(Estado), .Contagem(Contagem)
`ifdef TOTAL_CNT_EN
    , .Total(Total)
`endif
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  int nChk = 0, nFail = 0;
  int vCnt = 0, tCnt = 0, pCnt = 0;
  logic [27:0] sb[$];

  // Reference model state
  int mst = 0, mtmr = 0, mcnt = 0, mtot = 0;
  bit mpr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mst = 0; mtmr = 0; mcnt = 0; mtot = 0; mpr = 0;
  endtask

  task automatic modelStep();
    int nx;
    nx = mst;
    case (mst)
      0: if (Start) nx = TemR ? 1 : 5;
      1: if (!TemR) nx = 5; else if (!Start) nx = 0; else if (TemG) nx = 2;
      2: if (!TemR) nx = 5; else if (Cheia) nx = 3; else if (mtmr == FT-1) nx = 5;
      3: if (mtmr == CC-1) nx = 4;
      4: if (!TemG) nx = Start ? 1 : 0; else if (mtmr == FT-1) nx = 5;
      5: if (AckAlarme && TemR) nx = 0;
      default: nx = 0;
    endcase
    mpr = 0;
    if (mst == 3 && nx == 4) begin
      mcnt++;
      if (mcnt == CS) begin mcnt = 0; mpr = 1; end
      if (mtot < 65535) mtot++;
    end
    mtmr = (nx != mst) ? 0 : mtmr + 1;
    mst  = nx;
  endtask

  function automatic logic [27:0] modelVec();
    logic [15:0] t;
    t = 16'd0;
`ifdef TOTAL_CNT_EN
    t = 16'(mtot);
`endif
    return {t, 3'(mst), (mst == 1 || mst == 4), (mst == 2), (mst == 3), mpr, (mst == 5), 4'(mcnt)};
  endfunction

  function automatic logic [27:0] dutVec();
    return {totDut, Estado, Motor, Valvula, Tampar, Pronto, Alarme, Contagem};
  endfunction

  task automatic tick();
    modelStep();
    sb.push_back(modelVec());
    @(posedge CK); #1;
    chk("cycle", 32'(dutVec()), 32'(sb.pop_front()));
    if (Valvula) vCnt++;
    if (Tampar)  tCnt++;
    if (Pronto)  pCnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic waitState(input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (Estado != s && n < budget) begin tick(); n++; end
    chk("waitState", 32'(Estado), 32'(s));
  endtask

  // From AVANCA: one bottle filled for fillCyc cycles, ejected, back to AVANCA
  task automatic bottle(input int fillCyc);
    TemG = 1;
    waitState(3'd2, 5);
    ticks(fillCyc - 1);
    Cheia = 1; tick(); Cheia = 0;
    waitState(3'd4, 20);
    TemG = 0; tick();
  endtask

  initial begin
    int eCnt;
    nRST = 0; Start = 0; TemR = 0; TemG = 0; Cheia = 0; AckAlarme = 0;
    modelReset();
    repeat (2) @(posedge CK);
    #1;
    chk("rst_vec", 32'(dutVec()), 32'd0);
    #3 nRST = 1;
    tick();

    // Normal cycle
    Start = 1; TemR = 1;
    ticks(5);
    vCnt = 0; tCnt = 0;
    TemG = 1;
    waitState(3'd2, 5);
    ticks(9);
    Cheia = 1; tick(); Cheia = 0;
    waitState(3'd4, 20);
    ticks(2);
    TemG = 0; tick();
    chk("valv_cycles", 32'(vCnt), 32'd10);
    chk("tamp_cycles", 32'(tCnt), 32'd8);
    chk("cnt_one", 32'(Contagem), 32'd1);
    chk("back_avanca", 32'(Estado), 32'd1);

    // Rest of the crate
    pCnt = 0;
    for (int b = 0; b < 4; b++) bottle(3);
    chk("cnt_five", 32'(Contagem), 32'd5);
    bottle(2);
    chk("pronto_once", 32'(pCnt), 32'd1);
    chk("cnt_wrap", 32'(Contagem), 32'd0);
`ifdef TOTAL_CNT_EN
    chk("total_six", 32'(Total), 32'd6);
`endif

    // Fill timeout
    bottle(4);
    TemG = 1;
    waitState(3'd2, 5);
    eCnt = 1;
    for (int n = 0; n < 300 && Estado == 3'd2; n++) begin
      tick();
      if (Estado == 3'd2) eCnt++;
    end
    chk("fill_to_cycles", 32'(eCnt), 32'(FT));
    chk("to_alarme", 32'(Alarme), 32'd1);
    chk("to_valvula", 32'(Valvula), 32'd0);
    TemG = 0; Start = 0; AckAlarme = 1;
    tick(); AckAlarme = 0;
    chk("ack_idle", 32'(Estado), 32'd0);
    chk("to_cnt_kept", 32'(Contagem), 32'd1);

    // Reservoir loss together with Cheia
    Start = 1; tick();
    TemG = 1;
    waitState(3'd2, 5);
    ticks(3);
    Cheia = 1; TemR = 0; tick(); Cheia = 0; TemG = 0;
    chk("resv_erro", 32'(Estado), 32'd5);
    chk("resv_nocount", 32'(Contagem), 32'd1);
    AckAlarme = 1; ticks(3);
    chk("ack_no_res", 32'(Estado), 32'd5);
    TemR = 1; tick(); AckAlarme = 0;
    chk("ack_res_idle", 32'(Estado), 32'd0);

    // Start dropped mid-fill
    tick();
    TemG = 1;
    waitState(3'd2, 5);
    Start = 0;
    ticks(4);
    Cheia = 1; tick(); Cheia = 0;
    waitState(3'd4, 20);
    TemG = 0; tick();
    chk("drop_idle", 32'(Estado), 32'd0);
    chk("drop_motor", 32'(Motor), 32'd0);
    chk("drop_cnt", 32'(Contagem), 32'd2);

    // Async reset mid-TAMPA
    Start = 1; tick();
    TemG = 1;
    waitState(3'd2, 5);
    Cheia = 1; tick(); Cheia = 0;
    ticks(2);
    chk("pre_rst_tampa", 32'(Estado), 32'd3);
    #2 nRST = 0;
    #1;
    chk("arst_vec", 32'(dutVec()), 32'd0);
    modelReset();
    Start = 0; TemG = 0;
    #2 nRST = 1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", nChk, nFail);
    $finish;
  end
endmodule
